// File: rtl/scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : scan_sequencer
// Purpose  : Line-scan sequencer. Homes the film carrier, then alternates
//            CCD line capture (throttled by TX FIFO level) with carrier steps
//            and mechanical settle until the programmed line count is reached.
// Revision : 1.0  initial release
// ============================================================================
module scan_sequencer #(
    parameter int CNT_W    = 16,
    parameter int SETTLE_W = 24,
    parameter int TIMEOUT  = 2000000
) (
    input  logic                clk_100M,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [CNT_W-1:0]    num_lines,
    input  logic [CNT_W-1:0]    steps_per_line,
    input  logic [SETTLE_W-1:0] settle_cycles,
    input  logic                home_n,
    input  logic                step_ack,
    input  logic                line_done,
    input  logic                fifo_afull,
    output logic                mtr_en,
    output logic                mtr_dir,
    output logic                step_req,
    output logic                scan_en,
    output logic                busy,
    output logic                done,
    output logic                err_timeout,
    output logic [CNT_W-1:0]    line_cnt
);

    localparam int c_to_w  = $clog2(TIMEOUT + 1);
    localparam int c_tmr_w = (c_to_w > SETTLE_W) ? c_to_w : SETTLE_W;
    localparam logic [c_tmr_w-1:0] c_tmo_last = c_tmr_w'(TIMEOUT - 1);
    localparam logic [c_tmr_w-1:0] c_tmr_max  = '1;

    typedef enum logic [2:0] {
        S_IDLE         = 3'd0,
        S_HOME         = 3'd1,
        S_CAPTURE_WAIT = 3'd2,
        S_CAPTURE      = 3'd3,
        S_STEP         = 3'd4,
        S_SETTLE       = 3'd5,
        S_FINISH       = 3'd6,
        S_ERROR        = 3'd7
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    state_t              w_after_home;

    logic                r_step_req;
    logic                w_step_req_nxt;
    logic [CNT_W-1:0]    r_step_cnt;
    logic [CNT_W-1:0]    w_step_cnt_nxt;
    logic [CNT_W-1:0]    w_step_cnt_inc;
    logic [CNT_W-1:0]    r_line_cnt;
    logic [CNT_W-1:0]    w_line_cnt_nxt;
    logic [CNT_W-1:0]    w_line_inc;

    logic [CNT_W-1:0]    r_num_lines;
    logic [CNT_W-1:0]    r_steps;
    logic [SETTLE_W-1:0] r_settle;

    logic [c_tmr_w-1:0]  r_tmr;
    logic [c_tmr_w:0]    w_tmr_inc;
    logic [c_tmr_w:0]    w_settle_ext;
    logic                w_tmo;
    logic                w_settle_last;
    logic                w_latch;

    logic                r_mtr_en;
    logic                r_mtr_dir;
    logic                r_scan_en;
    logic                r_busy;
    logic                r_done;
    logic                r_err;

    assign w_step_cnt_inc = r_step_cnt + CNT_W'(1);
    assign w_line_inc     = r_line_cnt + CNT_W'(1);
    assign w_tmo          = (r_tmr == c_tmo_last);
    assign w_tmr_inc      = {1'b0, r_tmr} + (c_tmr_w + 1)'(1);
    assign w_settle_ext   = (c_tmr_w + 1)'(r_settle);
    // A zero settle still spends one cycle in SETTLE before capture resumes.
    assign w_settle_last  = (w_tmr_inc >= w_settle_ext);
    assign w_after_home   = (r_num_lines == '0) ? S_FINISH : S_CAPTURE_WAIT;

    always_ff @(posedge clk_100M) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_step_req_nxt = r_step_req;
        w_step_cnt_nxt = r_step_cnt;
        w_line_cnt_nxt = r_line_cnt;
        w_latch        = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt    = S_HOME;
                    w_latch        = 1'b1;
                    w_line_cnt_nxt = '0;
                end
            end
            S_HOME: begin
                if (w_tmo) begin
                    w_state_nxt = S_ERROR;
                end else if (r_step_req) begin
                    if (step_ack) begin
                        w_step_req_nxt = 1'b0;
                        if (!home_n) begin
                            w_state_nxt = w_after_home;
                        end
                    end
                end else if (!home_n) begin
                    w_state_nxt = w_after_home;
                end else begin
                    w_step_req_nxt = 1'b1;
                end
            end
            S_CAPTURE_WAIT: begin
                if (!fifo_afull) begin
                    w_state_nxt = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (w_tmo) begin
                    w_state_nxt = S_ERROR;
                end else if (line_done) begin
                    w_line_cnt_nxt = w_line_inc;
                    w_state_nxt    = (w_line_inc == r_num_lines) ? S_FINISH : S_STEP;
                end
            end
            S_STEP: begin
                if (r_step_req) begin
                    if (step_ack) begin
                        w_step_req_nxt = 1'b0;
                        w_step_cnt_nxt = w_step_cnt_inc;
                        if (w_step_cnt_inc == r_steps) begin
                            w_state_nxt = S_SETTLE;
                        end
                    end
                end else if (r_step_cnt == r_steps) begin
                    w_state_nxt = S_SETTLE;
                end else begin
                    w_step_req_nxt = 1'b1;
                end
            end
            S_SETTLE: begin
                if (w_settle_last) begin
                    w_state_nxt = S_CAPTURE_WAIT;
                end
            end
            S_FINISH: w_state_nxt = S_IDLE;
            S_ERROR:  w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase

        // Abort beats timeout and any normal transition; the line count is frozen.
        if (abort && (r_state != S_IDLE)) begin
            w_state_nxt    = S_IDLE;
            w_line_cnt_nxt = r_line_cnt;
        end

        if ((w_state_nxt != S_HOME) && (w_state_nxt != S_STEP)) begin
            w_step_req_nxt = 1'b0;
        end
        if ((w_state_nxt == S_STEP) && (r_state != S_STEP)) begin
            w_step_cnt_nxt = '0;
        end
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge clk_100M) begin
        if (rst) begin
            r_step_req  <= 1'b0;
            r_step_cnt  <= '0;
            r_line_cnt  <= '0;
            r_num_lines <= '0;
            r_steps     <= '0;
            r_settle    <= '0;
            r_tmr       <= '0;
            r_mtr_en    <= 1'b0;
            r_mtr_dir   <= 1'b0;
            r_scan_en   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_step_req <= w_step_req_nxt;
            r_step_cnt <= w_step_cnt_nxt;
            r_line_cnt <= w_line_cnt_nxt;

            if (w_latch) begin
                r_num_lines <= num_lines;
                r_steps     <= steps_per_line;
                r_settle    <= settle_cycles;
            end

            if (w_state_nxt != r_state) begin
                r_tmr <= '0;
            end else if (r_tmr != c_tmr_max) begin
                r_tmr <= r_tmr + c_tmr_w'(1);
            end

            r_mtr_en  <= (w_state_nxt == S_HOME) || (w_state_nxt == S_STEP);
            r_mtr_dir <= (w_state_nxt == S_STEP);
            r_scan_en <= (w_state_nxt == S_CAPTURE);
            r_busy    <= (w_state_nxt != S_IDLE);
            r_done    <= (w_state_nxt == S_FINISH);

            if (w_latch) begin
                r_err <= 1'b0;
            end else if (w_state_nxt == S_ERROR) begin
                r_err <= 1'b1;
            end
        end
    end

    assign mtr_en      = r_mtr_en;
    assign mtr_dir     = r_mtr_dir;
    assign step_req    = r_step_req;
    assign scan_en     = r_scan_en;
    assign busy        = r_busy;
    assign done        = r_done;
    assign err_timeout = r_err;
    assign line_cnt    = r_line_cnt;

endmodule
`default_nettype wire

// File: tb/tb_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_scan_sequencer
// Purpose  : Directed self-checking bench with stepper/CCD responders and a
//            line-count / done scoreboard.
// Revision : 1.0  initial release
// ============================================================================
module tb_scan_sequencer;

    localparam int CW      = 16;
    localparam int SW      = 24;
    localparam int TO      = 1000;
    localparam int CCD_LAT = 3;

    logic          clk_100M = 1'b0;
    logic          rst, start, abort;
    logic [CW-1:0] num_lines, steps_per_line;
    logic [SW-1:0] settle_cycles;
    logic          home_n, step_ack, line_done, fifo_afull;
    logic          mtr_en, mtr_dir, step_req, scan_en, busy, done, err_timeout;
    logic [CW-1:0] line_cnt;

    int total = 0;
    int bad   = 0;

    // Responder controls (written by the main sequence only)
    bit ack_en, ccd_en;
    int home_base, home_target, exp_gap;
    // Responder / monitor statistics (written by those processes only)
    int home_acks = 0, step_acks = 0;
    int scan_hi = 0, scan_rises = 0, done_cnt = 0, dir_viol = 0, gap_cnt = 0, gap_off = 0;
    // Baselines
    int b_home, b_step, b_hi, b_rise, b_done, b_viol, b_gcnt, b_goff;

    int exp_line_q[$];
    int exp_done_q[$];

    always #5 clk_100M = ~clk_100M;

    scan_sequencer #(
        .CNT_W    (CW),
        .SETTLE_W (SW),
        .TIMEOUT  (TO)
    ) dut (
        .clk_100M       (clk_100M),
        .rst            (rst),
        .start          (start),
        .abort          (abort),
        .num_lines      (num_lines),
        .steps_per_line (steps_per_line),
        .settle_cycles  (settle_cycles),
        .home_n         (home_n),
        .step_ack       (step_ack),
        .line_done      (line_done),
        .fifo_afull     (fifo_afull),
        .mtr_en         (mtr_en),
        .mtr_dir        (mtr_dir),
        .step_req       (step_req),
        .scan_en        (scan_en),
        .busy           (busy),
        .done           (done),
        .err_timeout    (err_timeout),
        .line_cnt       (line_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_100M);
    endtask

    task automatic snap();
        b_home = home_acks;  b_step = step_acks; b_hi   = scan_hi;
        b_rise = scan_rises; b_done = done_cnt;  b_viol = dir_viol;
        b_gcnt = gap_cnt;    b_goff = gap_off;
    endtask

    task automatic do_start(input int nl, input int spl, input int sc);
        num_lines      = CW'(nl);
        steps_per_line = CW'(spl);
        settle_cycles  = SW'(sc);
        start          = 1'b1;
        @(negedge clk_100M);
        start          = 1'b0;
    endtask

    // which: 0 done, 1 scan_en, 2 step_req in scan direction, 3 err_timeout, 4 line_cnt==1
    task automatic wait_until(input int which, input string tag, input int budget);
        bit hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(negedge clk_100M);
            case (which)
                0:       hit = done;
                1:       hit = scan_en;
                2:       hit = step_req && mtr_dir;
                3:       hit = err_timeout;
                default: hit = (line_cnt == CW'(1));
            endcase
        end
        chk(tag, 32'(hit), 32'(1));
    endtask

    // Stepper and CCD models plus the home switch
    initial begin
        int ccnt = 0;
        step_ack  = 1'b0;
        line_done = 1'b0;
        home_n    = 1'b1;
        forever begin
            @(negedge clk_100M);
            if (ack_en && step_req && !step_ack) begin
                step_ack = 1'b1;
                if (mtr_dir) step_acks++;
                else         home_acks++;
            end else begin
                step_ack = 1'b0;
            end
            home_n = ((home_acks - home_base) >= home_target) ? 1'b0 : 1'b1;
            if (scan_en && ccd_en && !line_done) begin
                ccnt++;
                if (ccnt >= CCD_LAT) begin
                    line_done = 1'b1;
                    ccnt      = 0;
                end
            end else begin
                line_done = 1'b0;
                if (!scan_en) ccnt = 0;
            end
        end
    end

    // Output monitor and scoreboard
    initial begin
        logic [CW-1:0] prev_line = '0;
        logic          prev_scan = 1'b0;
        bit            have_fall = 1'b0;
        int            idle_run  = 0;
        int            e;
        forever begin
            @(negedge clk_100M);
            if ((line_cnt != prev_line) && (line_cnt != '0)) begin
                if (exp_line_q.size() == 0) begin
                    chk("sb_line_unexpected", 32'(line_cnt), 32'(0));
                end else begin
                    e = exp_line_q.pop_front();
                    chk("sb_line_cnt", 32'(line_cnt), 32'(e));
                    chk("sb_scan_off_at_line", 32'(scan_en), 32'(0));
                end
            end
            prev_line = line_cnt;
            if (done) begin
                done_cnt++;
                if (exp_done_q.size() == 0) begin
                    chk("sb_done_unexpected", 32'(done), 32'(0));
                end else begin
                    e = exp_done_q.pop_front();
                    chk("sb_done_lines", 32'(line_cnt), 32'(e));
                end
            end
            if (scan_en) scan_hi++;
            if (scan_en && !prev_scan) scan_rises++;
            if (mtr_dir && (scan_en || !mtr_en)) dir_viol++;
            if (!busy) begin
                have_fall = 1'b0;
            end else if (prev_scan && !scan_en) begin
                have_fall = 1'b1;
                idle_run  = 0;
            end else if (!prev_scan && scan_en) begin
                if (have_fall) begin
                    gap_cnt++;
                    if (exp_gap >= 0 && idle_run != exp_gap) gap_off++;
                end
                have_fall = 1'b0;
            end else if (have_fall && !mtr_en && !scan_en) begin
                idle_run++;
            end
            prev_scan = scan_en;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; fifo_afull = 1'b0;
        num_lines = '0; steps_per_line = '0; settle_cycles = '0;
        ack_en = 1'b1; ccd_en = 1'b1; home_base = 0; home_target = 0; exp_gap = -1;
        tick(3);
        chk("reset_ctl", 32'({mtr_en, mtr_dir, step_req, scan_en, busy, done, err_timeout}), 32'(0));
        chk("reset_line_cnt", 32'(line_cnt), 32'(0));
        rst = 1'b0;
        tick(2);

        // Full scan: 3 lines, 4 steps/line, settle 10, carrier already home
        exp_gap = 11;
        snap();
        exp_line_q.push_back(1); exp_line_q.push_back(2); exp_line_q.push_back(3);
        exp_done_q.push_back(3);
        do_start(3, 4, 10);
        chk("A_start_busy", 32'(busy), 32'(1));
        chk("A_start_mtr_en", 32'(mtr_en), 32'(1));
        wait_until(0, "A_done_seen", 2000);
        tick(20);
        chk("A_windows", 32'(scan_rises - b_rise), 32'(3));
        chk("A_scan_cycles", 32'(scan_hi - b_hi), 32'(3 * CCD_LAT));
        chk("A_step_acks", 32'(step_acks - b_step), 32'(8));
        chk("A_home_acks", 32'(home_acks - b_home), 32'(0));
        chk("A_gaps", 32'(gap_cnt - b_gcnt), 32'(2));
        chk("A_gap_len_off", 32'(gap_off - b_goff), 32'(0));
        chk("A_line_cnt", 32'(line_cnt), 32'(3));
        chk("A_done_pulses", 32'(done_cnt - b_done), 32'(1));
        chk("A_idle_outputs", 32'({busy, mtr_en, step_req, scan_en}), 32'(0));

        // Homing after 5 steps, then 2 lines with 2 steps and zero settle
        home_base = home_acks; home_target = 5; exp_gap = 2;
        tick(2);
        snap();
        exp_line_q.push_back(1); exp_line_q.push_back(2);
        exp_done_q.push_back(2);
        do_start(2, 2, 0);
        wait_until(0, "B_done_seen", 2000);
        tick(5);
        chk("B_home_acks", 32'(home_acks - b_home), 32'(5));
        chk("B_step_acks", 32'(step_acks - b_step), 32'(2));
        chk("B_dir_viol", 32'(dir_viol - b_viol), 32'(0));
        chk("B_gap_len_off", 32'(gap_off - b_goff), 32'(0));
        chk("B_done_pulses", 32'(done_cnt - b_done), 32'(1));

        // FIFO throttle held for 100 cycles
        home_target = 0; exp_gap = -1; fifo_afull = 1'b1;
        tick(2);
        snap();
        exp_line_q.push_back(1); exp_done_q.push_back(1);
        do_start(1, 3, 2);
        tick(100);
        chk("C_scan_held_off", 32'(scan_hi - b_hi), 32'(0));
        chk("C_busy_waiting", 32'(busy), 32'(1));
        fifo_afull = 1'b0;
        tick(1);
        chk("C_scan_rise", 32'(scan_en), 32'(1));
        fifo_afull = 1'b1;
        wait_until(0, "C_done_despite_afull", 100);
        fifo_afull = 1'b0;
        chk("C_done_pulses", 32'(done_cnt - b_done), 32'(1));

        // line_done withheld: capture timeout
        ccd_en = 1'b0;
        tick(2);
        snap();
        do_start(2, 1, 1);
        wait_until(3, "D_err_seen", 1200);
        tick(2);
        chk("D_err_timeout", 32'(err_timeout), 32'(1));
        chk("D_busy", 32'(busy), 32'(0));
        chk("D_no_done", 32'(done_cnt - b_done), 32'(0));
        chk("D_scan_cycles", 32'(scan_hi - b_hi), 32'(TO));
        chk("D_line_cnt", 32'(line_cnt), 32'(0));
        ccd_en = 1'b1;
        exp_line_q.push_back(1); exp_done_q.push_back(1);
        do_start(1, 0, 0);
        chk("D_err_cleared", 32'(err_timeout), 32'(0));
        wait_until(0, "D_recover_done", 200);

        // Abort while a scan-direction step is pending
        ack_en = 1'b0;
        tick(2);
        snap();
        exp_line_q.push_back(1);
        do_start(3, 4, 0);
        wait_until(2, "E_step_pending", 300);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        chk("E_step_req", 32'(step_req), 32'(0));
        chk("E_mtr_en", 32'(mtr_en), 32'(0));
        chk("E_busy", 32'(busy), 32'(0));
        chk("E_line_cnt_held", 32'(line_cnt), 32'(1));
        tick(5);
        chk("E_no_done_no_err", 32'({err_timeout, busy}), 32'(0));
        chk("E_done_pulses", 32'(done_cnt - b_done), 32'(0));
        ack_en = 1'b1;

        // Zero lines: homing (3 steps) then done, no capture
        home_base = home_acks; home_target = 3;
        tick(2);
        snap();
        exp_done_q.push_back(0);
        do_start(0, 4, 5);
        wait_until(0, "F_done_seen", 500);
        tick(3);
        chk("F_scan_cycles", 32'(scan_hi - b_hi), 32'(0));
        chk("F_home_acks", 32'(home_acks - b_home), 32'(3));
        chk("F_step_acks", 32'(step_acks - b_step), 32'(0));
        chk("F_done_pulses", 32'(done_cnt - b_done), 32'(1));

        // Reset during the second capture, then a normal scan with zero steps
        home_target = 0;
        tick(2);
        exp_line_q.push_back(1);
        do_start(3, 1, 1);
        wait_until(4, "G_first_line", 300);
        ccd_en = 1'b0;
        wait_until(1, "G_second_capture", 300);
        rst = 1'b1;
        tick(1);
        chk("G_reset_ctl", 32'({mtr_en, mtr_dir, step_req, scan_en, busy, done, err_timeout}), 32'(0));
        chk("G_reset_line_cnt", 32'(line_cnt), 32'(0));
        rst = 1'b0; ccd_en = 1'b1; exp_gap = 4;
        tick(2);
        snap();
        exp_line_q.push_back(1); exp_line_q.push_back(2);
        exp_done_q.push_back(2);
        do_start(2, 0, 3);
        wait_until(0, "G_done_seen", 300);
        tick(3);
        chk("G_line_cnt", 32'(line_cnt), 32'(2));
        chk("G_step_acks", 32'(step_acks - b_step), 32'(0));
        chk("G_gaps", 32'(gap_cnt - b_gcnt), 32'(1));
        chk("G_gap_len_off", 32'(gap_off - b_goff), 32'(0));
        chk("G_done_pulses", 32'(done_cnt - b_done), 32'(1));

        chk("sb_lines_left", 32'(exp_line_q.size()), 32'(0));
        chk("sb_done_left", 32'(exp_done_q.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/scan_sequencer.md
# scan_sequencer

Line-scan sequencer between the control register block and the stepper, CCD timing and USB TX path. On a start command it:
- homes the film carrier;
- captures one CCD line per position;
- advances the carrier by a programmed number of motor steps, waits for mechanical settle, and repeats for a programmed number of lines;
- throttles line capture on TX FIFO occupancy so no pixel data is dropped.

## Interface
- `CNT_W`, 16, width of line-count and step-count operands
- `SETTLE_W`, 24, width of settle-delay operand (clk_100M cycles)
- `TIMEOUT`, 2000000, max clk_100M cycles waited for `line_done` or `home_n` before error
- `clk_100M`  in  1  system clock; all ports synchronous to it
- `rst`  in  1  synchronous active-high reset
- `start`  in  1  one-cycle pulse; begins a scan, accepted only in IDLE
- `abort`  in  1  one-cycle pulse; cancels any scan
- `num_lines`  in  CNT_W  lines to capture; sampled on accepted `start`
- `steps_per_line`  in  CNT_W  motor steps between lines; sampled on `start`
- `settle_cycles`  in  SETTLE_W  post-move delay; sampled on `start`
- `home_n`  in  1  home switch, active low, pre-synchronised
- `step_ack`  in  1  stepper completed one step (one-cycle pulse)
- `line_done`  in  1  CCD timing finished one line (one-cycle pulse, pre-synchronised)
- `fifo_afull`  in  1  TX FIFO almost full
- `mtr_en`  out  1  motor enable
- `mtr_dir`  out  1  0 = toward home, 1 = scan direction
- `step_req`  out  1  request one step; held until `step_ack`
- `scan_en`  out  1  CCD line capture enable
- `busy`  out  1  high in any state except IDLE
- `done`  out  1  one-cycle pulse on normal completion
- `err_timeout`  out  1  sticky; cleared by accepted `start` or `rst`
- `line_cnt`  out  CNT_W  lines completed in current scan

## Operation
- States: IDLE, HOME, CAPTURE_WAIT, CAPTURE, STEP, SETTLE, FINISH, ERROR.
- IDLE → HOME on `start`. On the same edge:
  - latch the three operands;
  - clear `line_cnt` and `err_timeout`.
- HOME:
  - `mtr_en`=1, `mtr_dir`=0, `step_req` asserted repeatedly;
  - the `home_n` check is made on each cycle the handshake completes: `home_n`=0 at that point → CAPTURE_WAIT;
  - `home_n` already 0 on HOME entry → CAPTURE_WAIT next cycle with no step issued.
- CAPTURE_WAIT: `scan_en`=0. `fifo_afull`=0 → CAPTURE.
- CAPTURE: `scan_en`=1 until `line_done`. Then:
  - `line_cnt`++;
  - if the new `line_cnt`==`num_lines` → FINISH, else → STEP.
- STEP:
  - `mtr_en`=1, `mtr_dir`=1;
  - issue `steps_per_line` handshakes, then → SETTLE;
  - `steps_per_line`=0 → SETTLE immediately.
- SETTLE: wait exactly `settle_cycles` cycles, then → CAPTURE_WAIT. `settle_cycles`=0 → CAPTURE_WAIT next cycle.
- FINISH: `done`=1 for one cycle, → IDLE. `mtr_en` stays 0 in IDLE.
- `num_lines`=0: HOME still runs, then FINISH directly, with no capture.
- Timeout:
  - a single counter is reset on every state entry;
  - reaching TIMEOUT in HOME or CAPTURE → ERROR;
  - ERROR sets `err_timeout` and drops all control outputs, → IDLE next cycle, no `done`.
- `abort` in any non-IDLE state → IDLE next cycle:
  - `step_req`, `scan_en`, `mtr_en` deassert on that edge;
  - `line_cnt` holds;
  - no `done`, no error.
- Priority (highest first): `rst` > `abort` > timeout > normal transition. `start` while busy is ignored.
- `line_done` outside CAPTURE is ignored. `step_ack` without `step_req` is ignored.

## Timing
- All outputs registered.
- Reset values: `mtr_en`=0, `mtr_dir`=0, `step_req`=0, `scan_en`=0, `busy`=0, `done`=0, `err_timeout`=0, `line_cnt`=0, state IDLE.
- `start` at edge N: `busy`=1 and `mtr_en`=1 at N+1.
- Step handshake:
  - `step_req` rises the cycle after entering STEP/HOME;
  - on `step_ack`, `step_req` drops for at least one cycle before the next request;
  - each step therefore costs at least 2 cycles plus ack latency.
- `line_done` at edge N: `scan_en`=0 and `line_cnt` updated at N+1.
- `done` is asserted the cycle after the final `line_done` is sampled.
- SETTLE duration is exactly `settle_cycles` cycles with `scan_en`=0.
- `fifo_afull` is only sampled in CAPTURE_WAIT. Once CAPTURE is entered, the line completes regardless of `fifo_afull`.
- Counters do not wrap. `line_cnt` max is 2^CNT_W−1, bounded by `num_lines`.

## Test plan
- Reset mid-CAPTURE (`scan_en`=1) → all outputs at reset values the next cycle; a subsequent `start` behaves normally.
- `home_n`=0 at start, `num_lines`=3, `steps_per_line`=4, `settle_cycles`=10, immediate acks → 3 `scan_en` windows, 8 `step_ack`s total, each gap ≥10 cycles of SETTLE, `line_cnt`=3, one `done`.
- Homing: `home_n` goes low after 5 acks → exactly 5 steps with `mtr_dir`=0, then first capture with `mtr_dir`=1 only during STEP.
- `fifo_afull` held high for 100 cycles in CAPTURE_WAIT → `scan_en` stays 0 for those cycles, rises 1 cycle after `fifo_afull` falls.
- `line_done` withheld, TIMEOUT=1000 → `err_timeout`=1, `busy`=0, no `done`; the next `start` clears `err_timeout`.
- `abort` during STEP with `step_req`=1 → `step_req`=0, `mtr_en`=0, `busy`=0 next cycle, `line_cnt` unchanged. `num_lines`=0 → homing then `done`, zero `scan_en` cycles.
